// File: rtl/npu_pkg.sv
// Shared NPU constants and types for the MRF write-side loader.
// Geometry: EW-bit elements, DOTW per row, one BW-bit beat per DSP chunk.
package npu_pkg;

    // Element width and dot-product width of one engine.
    localparam int EW      = 8;
    localparam int DOTW    = 40;

    // One beat carries the ten elements of a single DSP chunk.
    localparam int NUM_DSP = DOTW / 10;
    localparam int BW      = EW * 10;
    localparam int DW      = EW * DOTW;

    // MRF geometry.
    localparam int DEPTH   = 512;
    localparam int AW      = 9;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } mrf_ld_state_t;

endpackage

// File: rtl/mrf_loader_packer.sv
// mrf_row_packer: gathers NUM_DSP beats into one MRF row, first beat in the
// MSB chunk. Ports: clk, rst (async active-low), clr_i, beat_i, data_i,
// row_valid_o (last beat of a row accepted this cycle), row_data_o (row
// including the beat accepted this cycle).
module mrf_row_packer
    import npu_pkg::*;
#(
    parameter int P_NUM_DSP = NUM_DSP,
    parameter int P_BW      = BW
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr_i,
    input  logic                       beat_i,
    input  logic [P_BW-1:0]            data_i,
    output logic                       row_valid_o,
    output logic [P_NUM_DSP*P_BW-1:0]  row_data_o
);

    localparam int RW = P_NUM_DSP * P_BW;
    localparam int CW = (P_NUM_DSP > 1) ? $clog2(P_NUM_DSP) : 1;
    localparam logic [CW-1:0] LAST = CW'(P_NUM_DSP - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] row_q, row_d;

    always_comb begin
        cnt_d = cnt_q;
        row_d = row_q;
        if (beat_i) begin
            // Beat k fills chunk NUM_DSP-1-k, so beat 0 ends up in the MSBs.
            for (int i = 0; i < P_NUM_DSP; i++) begin
                if (cnt_q == CW'(i)) begin
                    row_d[(P_NUM_DSP-1-i)*P_BW +: P_BW] = data_i;
                end
            end
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
        if (clr_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            row_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            row_q <= row_d;
        end
    end

    assign row_valid_o = beat_i && (cnt_q == LAST);
    assign row_data_o  = row_d;

endmodule

// File: rtl/mrf_loader.sv
// mrf_loader: accepts (base, rows) load commands and streams packed weight
// rows into the MRF. Ports: clk, rst (async active-low); cmd_valid/ready,
// cmd_base, cmd_rows; in_valid/ready, in_data (one DSP chunk per beat);
// wr_en/wr_addr/wr_data (registered MRF write port); busy; done (pulse).
module mrf_loader
    import npu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_base,
    input  logic [AW:0]   cmd_rows,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [BW-1:0] in_data,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          busy,
    output logic          done
);

    mrf_ld_state_t state_q, state_d;

    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   rows_q, rows_d;
    logic [AW:0]   row_cnt_q, row_cnt_d;

    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic          done_q, done_d;

    logic          cmd_fire;
    logic          beat_fire;
    logic          pk_clr;
    logic          row_valid;
    logic [DW-1:0] row_data;

    // Held low during reset so no command can slip in on release.
    assign cmd_ready = rst && (state_q == IDLE);
    assign in_ready  = (state_q == LOAD);
    assign busy      = (state_q == LOAD);

    assign cmd_fire  = cmd_valid && cmd_ready;
    assign beat_fire = in_valid && in_ready;

    mrf_row_packer #(
        .P_NUM_DSP (NUM_DSP),
        .P_BW      (BW)
    ) u_packer (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (pk_clr),
        .beat_i      (beat_fire),
        .data_i      (in_data),
        .row_valid_o (row_valid),
        .row_data_o  (row_data)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rows_d    = rows_q;
        row_cnt_d = row_cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        pk_clr    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    rows_d = cmd_rows;
                    if (cmd_rows == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d   = LOAD;
                        addr_d    = cmd_base;
                        row_cnt_d = '0;
                        pk_clr    = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (row_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = row_data;
                    // AW-bit address wraps DEPTH-1 -> 0 on its own.
                    addr_d    = addr_q + 1'b1;
                    row_cnt_d = row_cnt_q + 1'b1;
                    if (row_cnt_q == rows_q - 1'b1) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rows_q    <= '0;
            row_cnt_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rows_q    <= rows_d;
            row_cnt_q <= row_cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign done    = done_q;

endmodule

// File: tb/tb_mrf_loader.sv
// Directed bench for mrf_loader: reset, single/multi-row, wrap, zero rows,
// back-to-back commands and reset in the middle of a row.
module tb_mrf_loader;
    import npu_pkg::*;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_base;
    logic [AW:0]   cmd_rows;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] in_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          done;

    int nvec = 0;
    int nmis = 0;
    int done_cnt = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          dn;
    } wr_t;

    wr_t wq[$];

    mrf_loader dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_base  (cmd_base),
        .cmd_rows  (cmd_rows),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every write and done pulse away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            if (wr_en) wq.push_back('{a: wr_addr, d: wr_data, dn: done});
            if (done) done_cnt++;
        end
    end

    task automatic check(input string tag, input logic [511:0] got,
                         input logic [511:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] mk(input logic [7:0] t);
        return {(BW/8){t}};
    endfunction

    // NUM_DSP = 4: first beat is the MSB chunk.
    function automatic logic [DW-1:0] row_exp(input logic [7:0] t);
        return {mk(t), mk(t + 8'd1), mk(t + 8'd2), mk(t + 8'd3)};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_cmd(input logic [AW-1:0] b, input logic [AW:0] r);
        int n;
        n = 0;
        while (!cmd_ready && n < 100) begin
            tick(1);
            n++;
        end
        check("cmd_ready_wait", {511'd0, cmd_ready}, 512'd1);
        cmd_valid = 1'b1;
        cmd_base  = b;
        cmd_rows  = r;
        tick(1);
        cmd_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] t);
        int n;
        in_valid = 1'b1;
        in_data  = mk(t);
        n = 0;
        while (!in_ready && n < 100) begin
            tick(1);
            n++;
        end
        if (!in_ready) check("in_ready_wait", 512'd0, 512'd1);
        tick(1);
    endtask

    task automatic send_row(input logic [7:0] t, input int gap);
        for (int k = 0; k < NUM_DSP; k++) begin
            if (gap > 0) begin
                in_valid = 1'b0;
                tick(gap);
            end
            send_beat(t + 8'(k));
        end
        in_valid = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] ea[4];
        logic [7:0]    et[4];
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_base  = '0;
        cmd_rows  = '0;
        in_valid  = 1'b0;
        in_data   = '0;

        // Reset state.
        #3 rst = 1'b0;
        #4;
        check("rst_wr_en", {511'd0, wr_en}, 512'd0);
        check("rst_done", {511'd0, done}, 512'd0);
        check("rst_busy", {511'd0, busy}, 512'd0);
        check("rst_in_ready", {511'd0, in_ready}, 512'd0);
        check("rst_cmd_ready", {511'd0, cmd_ready}, 512'd0);
        check("rst_wr_addr", 512'(wr_addr), 512'd0);
        check("rst_wr_data", 512'(wr_data), 512'd0);
        tick(2);
        @(negedge clk);
        rst = 1'b1;
        tick(1);
        check("idle_cmd_ready", {511'd0, cmd_ready}, 512'd1);

        // Single row at base 5.
        wq.delete();
        done_cnt = 0;
        send_cmd(9'd5, 10'd1);
        check("s_busy", {511'd0, busy}, 512'd1);
        check("s_in_ready", {511'd0, in_ready}, 512'd1);
        send_row(8'h0A, 0);
        check("s_wr_en", {511'd0, wr_en}, 512'd1);
        check("s_wr_addr", 512'(wr_addr), 512'd5);
        check("s_wr_data", 512'(wr_data), 512'(row_exp(8'h0A)));
        check("s_done", {511'd0, done}, 512'd1);
        check("s_busy_fall", {511'd0, busy}, 512'd0);
        check("s_cmd_ready", {511'd0, cmd_ready}, 512'd1);
        tick(1);
        check("s_wr_en_off", {511'd0, wr_en}, 512'd0);
        check("s_done_off", {511'd0, done}, 512'd0);
        check("s_hold_data", 512'(wr_data), 512'(row_exp(8'h0A)));
        check("s_hold_addr", 512'(wr_addr), 512'd5);

        // Three rows with a one-cycle gap before every beat.
        wq.delete();
        done_cnt = 0;
        send_cmd(9'd0, 10'd3);
        send_row(8'h10, 1);
        send_row(8'h20, 1);
        send_row(8'h30, 1);
        tick(3);
        check("m_count", 512'(wq.size()), 512'd3);
        check("m_done_cnt", 512'(done_cnt), 512'd1);
        ea = '{9'd0, 9'd1, 9'd2, 9'd0};
        et = '{8'h10, 8'h20, 8'h30, 8'h00};
        for (int i = 0; i < 3 && i < wq.size(); i++) begin
            check($sformatf("m_addr%0d", i), 512'(wq[i].a), 512'(ea[i]));
            check($sformatf("m_data%0d", i), 512'(wq[i].d),
                  512'(row_exp(et[i])));
            check($sformatf("m_done%0d", i), {511'd0, wq[i].dn},
                  (i == 2) ? 512'd1 : 512'd0);
        end

        // Address wrap 510, 511, 0, 1.
        wq.delete();
        done_cnt = 0;
        send_cmd(9'd510, 10'd4);
        send_row(8'h40, 0);
        send_row(8'h50, 0);
        send_row(8'h60, 0);
        send_row(8'h70, 0);
        tick(3);
        check("w_count", 512'(wq.size()), 512'd4);
        check("w_done_cnt", 512'(done_cnt), 512'd1);
        ea = '{9'd510, 9'd511, 9'd0, 9'd1};
        et = '{8'h40, 8'h50, 8'h60, 8'h70};
        for (int i = 0; i < 4 && i < wq.size(); i++) begin
            check($sformatf("w_addr%0d", i), 512'(wq[i].a), 512'(ea[i]));
            check($sformatf("w_data%0d", i), 512'(wq[i].d),
                  512'(row_exp(et[i])));
            check($sformatf("w_done%0d", i), {511'd0, wq[i].dn},
                  (i == 3) ? 512'd1 : 512'd0);
        end

        // Zero rows: done one cycle after acceptance, no write.
        wq.delete();
        done_cnt = 0;
        in_valid = 1'b1;
        in_data  = mk(8'hEE);
        send_cmd(9'd33, 10'd0);
        check("z_done", {511'd0, done}, 512'd1);
        check("z_in_ready", {511'd0, in_ready}, 512'd0);
        check("z_busy", {511'd0, busy}, 512'd0);
        tick(1);
        check("z_done_off", {511'd0, done}, 512'd0);
        check("z_in_ready2", {511'd0, in_ready}, 512'd0);
        tick(3);
        in_valid = 1'b0;
        check("z_no_write", 512'(wq.size()), 512'd0);
        check("z_done_cnt", 512'(done_cnt), 512'd1);

        // Back-to-back: second command accepted in the final-write cycle.
        wq.delete();
        done_cnt = 0;
        send_cmd(9'd100, 10'd1);
        send_row(8'h80, 0);
        check("b_wr_en", {511'd0, wr_en}, 512'd1);
        check("b_cmd_ready", {511'd0, cmd_ready}, 512'd1);
        cmd_valid = 1'b1;
        cmd_base  = 9'd200;
        cmd_rows  = 10'd1;
        tick(1);
        cmd_valid = 1'b0;
        check("b_busy2", {511'd0, busy}, 512'd1);
        send_row(8'h90, 0);
        tick(2);
        check("b_count", 512'(wq.size()), 512'd2);
        check("b_done_cnt", 512'(done_cnt), 512'd2);
        if (wq.size() == 2) begin
            check("b_addr0", 512'(wq[0].a), 512'd100);
            check("b_addr1", 512'(wq[1].a), 512'd200);
            check("b_data1", 512'(wq[1].d), 512'(row_exp(8'h90)));
        end

        // Reset after two of four beats.
        wq.delete();
        done_cnt = 0;
        send_cmd(9'd7, 10'd1);
        send_beat(8'hC0);
        send_beat(8'hC1);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("r_wr_addr", 512'(wr_addr), 512'd0);
        check("r_wr_data", 512'(wr_data), 512'd0);
        check("r_busy", {511'd0, busy}, 512'd0);
        check("r_in_ready", {511'd0, in_ready}, 512'd0);
        check("r_cmd_ready", {511'd0, cmd_ready}, 512'd0);
        tick(2);
        @(negedge clk);
        rst = 1'b1;
        tick(4);
        check("r_no_write", 512'(wq.size()), 512'd0);
        check("r_idle", {511'd0, busy}, 512'd0);
        send_cmd(9'd9, 10'd1);
        send_row(8'hE0, 0);
        check("r_new_en", {511'd0, wr_en}, 512'd1);
        check("r_new_addr", 512'(wr_addr), 512'd9);
        check("r_new_data", 512'(wr_data), 512'(row_exp(8'hE0)));
        check("r_new_done", {511'd0, done}, 512'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
